// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory
// wait states with timeout, and delay-slot annulment.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RS1_ID,
   input  logic [4:0]       RS2_ID,
   input  logic [4:0]       RD_ID,
   input  logic             USE_RS2_ID,
   input  logic             STORE_ID,
   input  logic [4:0]       RD_EX,
   input  logic             RF_LE_EX,
   input  logic             LOAD_EX,
   input  logic             MEM_ACC_MEM,
   input  logic             MEM_READY,
   input  logic             ANNUL_ID,
   output logic             PC_LE,
   output logic             IF_ID_LE,
   output logic             IF_ID_CLR,
   output logic             ID_EX_NOP,
   output logic             EX_MEM_LE,
   output logic             MEM_WB_LE,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic             MEM_ERR
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_ERR      = 2'd2
   } state_t;

   localparam logic [7:0]       TIMEOUT_W = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           r_state;
   logic [7:0]       r_wait_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_mem_err;

   logic w_mem_hold;
   logic w_lu;
   logic w_freeze;

   assign w_mem_hold = MEM_ACC_MEM && !MEM_READY;

   // Only a load still in EX needs a bubble; later producers are forwarded.
   assign w_lu = LOAD_EX && RF_LE_EX && (RD_EX != 5'd0) &&
                 ((RD_EX == RS1_ID) ||
                  (USE_RS2_ID && (RD_EX == RS2_ID)) ||
                  (STORE_ID && (RD_EX == RD_ID)));

   always_comb begin
      w_freeze = 1'b0;
      case (r_state)
         S_RUN:      w_freeze = w_mem_hold;
         S_MEM_WAIT: w_freeze = !MEM_READY;
         default:    w_freeze = 1'b1;
      endcase
   end

   always_comb begin
      PC_LE     = 1'b1;
      IF_ID_LE  = 1'b1;
      IF_ID_CLR = 1'b0;
      ID_EX_NOP = 1'b0;
      EX_MEM_LE = 1'b1;
      MEM_WB_LE = 1'b1;
      if (reset) begin
         PC_LE     = 1'b0;
         IF_ID_LE  = 1'b0;
         ID_EX_NOP = 1'b1;
         EX_MEM_LE = 1'b0;
         MEM_WB_LE = 1'b0;
      end else if (w_freeze) begin
         PC_LE     = 1'b0;
         IF_ID_LE  = 1'b0;
         EX_MEM_LE = 1'b0;
         MEM_WB_LE = 1'b0;
      end else if (w_lu) begin
         // Stall beats annul: the branch stays in ID and re-asserts ANNUL_ID.
         PC_LE     = 1'b0;
         IF_ID_LE  = 1'b0;
         ID_EX_NOP = 1'b1;
      end else if (ANNUL_ID) begin
         IF_ID_CLR = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_wait_cnt  <= 8'd0;
         r_stall_cnt <= '0;
         r_mem_err   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_mem_hold) begin
                  r_state    <= S_MEM_WAIT;
                  r_wait_cnt <= 8'd1;
               end
            end
            S_MEM_WAIT: begin
               if (MEM_READY) begin
                  r_state    <= S_RUN;
                  r_wait_cnt <= 8'd0;
               end else if (r_wait_cnt == TIMEOUT_W) begin
                  r_state   <= S_ERR;
                  r_mem_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            S_ERR: begin
               r_mem_err <= 1'b1;
            end
            default: begin
               r_state <= S_ERR;
            end
         endcase
         if (!PC_LE && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
      end
   end

   assign STALL_CNT = r_stall_cnt;
   assign MEM_ERR   = r_mem_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed test of pipeline_hazard_ctrl: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 4;

   // {PC_LE, IF_ID_LE, IF_ID_CLR, ID_EX_NOP, EX_MEM_LE, MEM_WB_LE}
   localparam logic [5:0] RUNV   = 6'b110011;
   localparam logic [5:0] STALLV = 6'b000111;
   localparam logic [5:0] FRZV   = 6'b000000;
   localparam logic [5:0] ANNV   = 6'b111011;
   localparam logic [5:0] RSTV   = 6'b000100;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] RS1_ID, RS2_ID, RD_ID, RD_EX;
   logic USE_RS2_ID, STORE_ID, RF_LE_EX, LOAD_EX, MEM_ACC_MEM, MEM_READY, ANNUL_ID;
   logic PC_LE, IF_ID_LE, IF_ID_CLR, ID_EX_NOP, EX_MEM_LE, MEM_WB_LE;
   logic [CNT_W-1:0] STALL_CNT;
   logic MEM_ERR;

   typedef struct {
      string      nm;
      logic [5:0] ov;
      int         cnt;
      bit         err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
      .USE_RS2_ID(USE_RS2_ID), .STORE_ID(STORE_ID),
      .RD_EX(RD_EX), .RF_LE_EX(RF_LE_EX), .LOAD_EX(LOAD_EX),
      .MEM_ACC_MEM(MEM_ACC_MEM), .MEM_READY(MEM_READY), .ANNUL_ID(ANNUL_ID),
      .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_CLR(IF_ID_CLR),
      .ID_EX_NOP(ID_EX_NOP), .EX_MEM_LE(EX_MEM_LE), .MEM_WB_LE(MEM_WB_LE),
      .STALL_CNT(STALL_CNT), .MEM_ERR(MEM_ERR)
   );

   task automatic set_in(input bit ld, input bit rfle, input int rdex,
                         input int rs1, input int rs2, input bit use2,
                         input bit st, input int rdid,
                         input bit acc, input bit rdy, input bit ann);
      LOAD_EX = ld; RF_LE_EX = rfle; RD_EX = 5'(rdex);
      RS1_ID = 5'(rs1); RS2_ID = 5'(rs2); USE_RS2_ID = use2;
      STORE_ID = st; RD_ID = 5'(rdid);
      MEM_ACC_MEM = acc; MEM_READY = rdy; ANNUL_ID = ann;
   endtask

   task automatic idle();
      set_in(0, 0, 9, 1, 2, 1, 0, 3, 0, 1, 0);
   endtask

   // Queue the expected response for the current cycle, then advance one cycle.
   task automatic cyc(input string nm, input logic [5:0] ov, input int cnt, input bit err);
      exp_t e;
      e.nm = nm; e.ov = ov; e.cnt = cnt; e.err = err;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   initial begin : monitor
      exp_t e;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {PC_LE, IF_ID_LE, IF_ID_CLR, ID_EX_NOP, EX_MEM_LE, MEM_WB_LE};
            checks += 3;
            if (act !== e.ov) begin
               errors++;
               $display("FAIL %s enables got %b want %b", e.nm, act, e.ov);
            end
            if (int'(STALL_CNT) != e.cnt || $isunknown(STALL_CNT)) begin
               errors++;
               $display("FAIL %s stall_cnt got %0d want %0d", e.nm, STALL_CNT, e.cnt);
            end
            if (MEM_ERR !== e.err) begin
               errors++;
               $display("FAIL %s mem_err got %b want %b", e.nm, MEM_ERR, e.err);
            end
            $display("txn %-14s en=%b cnt=%0d err=%b", e.nm, act, STALL_CNT, MEM_ERR);
         end
      end
   end

   initial begin : driver
      int waited;
      reset = 1'b1;
      idle();
      @(posedge clk); #1;
      cyc("reset", RSTV, 0, 0);
      reset = 1'b0;

      // Load-use on rs1, then the load has moved on
      set_in(1, 1, 5, 5, 2, 1, 0, 3, 0, 1, 0); cyc("lu_rs1", STALLV, 0, 0);
      idle();                                  cyc("lu_after", RUNV, 1, 0);
      // r0 never stalls
      set_in(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0); cyc("lu_r0", RUNV, 1, 0);
      // rs2 ignored when immediate form
      set_in(1, 1, 7, 1, 7, 0, 0, 3, 0, 1, 0); cyc("lu_rs2_imm", RUNV, 1, 0);
      set_in(1, 1, 7, 1, 7, 1, 0, 3, 0, 1, 0); cyc("lu_rs2", STALLV, 1, 0);
      idle();                                  cyc("lu_rs2_after", RUNV, 2, 0);
      // Store data source
      set_in(1, 1, 7, 1, 2, 1, 1, 7, 0, 1, 0); cyc("lu_store", STALLV, 2, 0);
      // No register write or not a load: forwarding covers it
      set_in(1, 0, 5, 5, 2, 1, 0, 3, 0, 1, 0); cyc("lu_no_rfle", RUNV, 3, 0);
      set_in(0, 1, 5, 5, 2, 1, 0, 3, 0, 1, 0); cyc("alu_fwd", RUNV, 3, 0);

      // Memory wait of 3 cycles
      set_in(0, 0, 9, 1, 2, 1, 0, 3, 1, 0, 0); cyc("mwait1", FRZV, 3, 0);
      cyc("mwait2", FRZV, 4, 0);
      cyc("mwait3", FRZV, 5, 0);
      MEM_READY = 1'b1;                        cyc("mready", RUNV, 6, 0);
      idle();                                  cyc("mdone", RUNV, 6, 0);

      // Annul alone, then annul together with load-use
      set_in(0, 0, 9, 1, 2, 1, 0, 3, 0, 1, 1); cyc("annul", ANNV, 6, 0);
      set_in(1, 1, 4, 4, 2, 1, 0, 3, 0, 1, 1); cyc("annul_lu", STALLV, 6, 0);
      set_in(0, 0, 9, 4, 2, 1, 0, 3, 0, 1, 1); cyc("annul_retry", ANNV, 7, 0);
      idle();                                  cyc("post_annul", RUNV, 7, 0);

      // Timeout with MEM_TIMEOUT=4, then counter saturation in ERR
      set_in(0, 0, 9, 1, 2, 1, 0, 3, 1, 0, 0); cyc("to1", FRZV, 7, 0);
      cyc("to2", FRZV, 8, 0);
      cyc("to3", FRZV, 9, 0);
      cyc("to4", FRZV, 10, 0);
      cyc("to5", FRZV, 11, 0);
      cyc("err_entered", FRZV, 12, 1);
      MEM_READY = 1'b1;                        cyc("err_ready", FRZV, 13, 1);
      idle();                                  cyc("err_idle", FRZV, 14, 1);
      cyc("err_cnt15", FRZV, 15, 1);
      cyc("err_sat", FRZV, 15, 1);
      reset = 1'b1;                            cyc("reset_err", RSTV, 15, 1);
      reset = 1'b0;                            cyc("after_err", RUNV, 0, 0);

      // Reset while in MEM_WAIT
      set_in(0, 0, 9, 1, 2, 1, 0, 3, 1, 0, 0); cyc("mw_a", FRZV, 0, 0);
      cyc("mw_b", FRZV, 1, 0);
      reset = 1'b1;                            cyc("reset_mw", RSTV, 2, 0);
      reset = 1'b0;
      set_in(0, 0, 9, 1, 2, 1, 0, 3, 0, 0, 0); cyc("after_mw", RUNV, 0, 0);
      idle();                                  cyc("final", RUNV, 0, 0);

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk); #1;
         waited++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle whether PC/nPC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers load, hold, or take a bubble.
- Covers load-use hazards that forwarding cannot resolve, data-memory wait states with a timeout, and annulment of the delay-slot instruction.
- Sits beside the forwarding unit. It drives the pipeline-register load enables and the ID/EX bubble mux select.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive cycles MEM_READY may stay low before the ERR state; range 1..255.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- RS1_ID  input  5  rs1 of the instruction in ID
- RS2_ID  input  5  rs2 of the instruction in ID
- RD_ID  input  5  rd of the instruction in ID (store data source)
- USE_RS2_ID  input  1  ID instruction reads rs2 (0 when i=1 immediate)
- STORE_ID  input  1  ID instruction is a store (reads RD_ID)
- RD_EX  input  5  destination register in EX
- RF_LE_EX  input  1  EX instruction writes the register file
- LOAD_EX  input  1  EX instruction is a load
- MEM_ACC_MEM  input  1  MEM-stage instruction accesses data memory
- MEM_READY  input  1  data memory completes the access this cycle
- ANNUL_ID  input  1  branch in ID annuls its delay slot
- PC_LE  output  1  PC and nPC load enable
- IF_ID_LE  output  1  IF/ID load enable
- IF_ID_CLR  output  1  IF/ID loads a NOP instead of the fetched word
- ID_EX_NOP  output  1  ID/EX loads all-zero control (bubble)
- EX_MEM_LE  output  1  EX/MEM load enable
- MEM_WB_LE  output  1  MEM/WB load enable
- STALL_CNT  output  CNT_W  saturating count of cycles with PC_LE=0
- MEM_ERR  output  1  sticky memory-timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Outputs are Mealy (state plus current inputs). The state, wait counter, STALL_CNT and MEM_ERR are registered.
- Reset (synchronous):
  - State goes to RUN; wait counter, STALL_CNT and MEM_ERR go to 0.
  - In the reset cycle the outputs are forced to PC_LE=0, IF_ID_LE=0, IF_ID_CLR=0, ID_EX_NOP=1, EX_MEM_LE=0, MEM_WB_LE=0.
  - Reset mid-stall or in ERR returns to RUN on the next edge.
- mem_hold = MEM_ACC_MEM && !MEM_READY. It has the highest priority.
- RUN with mem_hold:
  - All load enables are 0, ID_EX_NOP=0, IF_ID_CLR=0 (the whole pipeline freezes).
  - Next state is MEM_WAIT and the wait counter is set to 1.
- MEM_WAIT:
  - Outputs are frozen as above.
  - If MEM_READY=1: return to RUN and clear the wait counter. That same cycle is evaluated with RUN rules, with mem_hold taken as 0.
  - Else if wait counter == MEM_TIMEOUT: go to ERR and set MEM_ERR.
  - Else: increment the wait counter.
- ERR:
  - Pipeline stays frozen until reset. MEM_ERR stays 1.
- Load-use hazard:
  - lu = LOAD_EX && RF_LE_EX && RD_EX!=0 && (RD_EX==RS1_ID || (USE_RS2_ID && RD_EX==RS2_ID) || (STORE_ID && RD_EX==RD_ID)).
  - In RUN with no mem_hold and lu=1: PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1, EX_MEM_LE=1, MEM_WB_LE=1. This is exactly one bubble; the load advances to MEM next cycle, so lu clears naturally.
  - r0 never causes a stall.
- Annul:
  - In RUN with no mem_hold, no lu and ANNUL_ID=1: IF_ID_CLR=1 for one cycle, with all enables 1.
  - If lu and ANNUL_ID are asserted together, the stall wins and IF_ID_CLR=0. The branch is held in ID and re-presents ANNUL_ID next cycle.
- Normal RUN: all enables 1, ID_EX_NOP=0, IF_ID_CLR=0.
- STALL_CNT increments on every edge where PC_LE=0 and reset=0. It saturates at all-ones with no wrap.

Test Plan:
- Load-use:
  - Stimulus: LOAD_EX=1, RF_LE_EX=1, RD_EX=5, RS1_ID=5, no mem access.
  - Response: one cycle of PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1, EX_MEM_LE=1; STALL_CNT goes 0→1. Next cycle, with LOAD_EX=0, all enables are 1.
- Non-stall cases:
  - Case A: RD_EX=0 and RS1_ID=0. Required: no stall.
  - Case B: RD_EX=7, RS2_ID=7, USE_RS2_ID=0. Required: no stall.
  - Case C: STORE_ID=1, RD_ID=7, RD_EX=7 with a load in EX. Required: stall.
- Memory wait:
  - Stimulus: MEM_ACC_MEM=1, MEM_READY=0 for 3 cycles, then 1.
  - Response: all enables 0 for 3 cycles, then RUN; STALL_CNT increases by 3; MEM_ERR=0.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, MEM_READY held 0.
  - Response: MEM_ERR=1 after the 5th frozen cycle; MEM_ERR stays 1 after MEM_READY=1; cleared only by reset.
- Annul:
  - Stimulus: ANNUL_ID=1 alone.
  - Response: IF_ID_CLR=1, PC_LE=1. When ANNUL_ID and lu are asserted together, IF_ID_CLR=0 and a bubble is inserted; IF_ID_CLR=1 on the following cycle.
- Reset mid-MEM_WAIT:
  - Stimulus: reset=1 for one cycle.
  - Response: during the reset cycle, outputs match the reset values listed in Behaviour. After reset, the FSM is in RUN with STALL_CNT=0.
